i2c_master_byte: RTL and testbench
==================================

# i2c_master_byte

Single-master I2C initiator for the CPLD. It performs one complete single-byte transaction (START, 7-bit address plus R/W, one data byte, STOP) per command. It drives SCL and SDA open-drain through pull-low enables, and top level wires them to I2C_SCL/I2C_SDA exactly like the slave port expander. Intended use: a host or local controller writes LED bytes to, and reads Button bytes from, port expanders on the same bus, default address 7'b1010110.

## Interface
Parameters:
- QTR_DIV, 250: PCLK cycles per quarter SCL period (250 gives 100 kHz at 100 MHz); legal range 2..1023.

Ports:
- PCLK  input  1  sole clock; all logic on rising edge.
- RESET_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  request a transaction; sampled only when busy=0.
- cmd_rw  input  1  0 = write, 1 = read.
- cmd_addr  input  7  slave address.
- cmd_wdata  input  8  byte to write (ignored for read).
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse when STOP completes.
- ack_error  output  1  slave NACKed address or write data; valid with done, held until next accept.
- rdata  output  8  byte read; valid with done for reads, held until next read completes.
- scl_in  input  1  sampled I2C_SCL.
- sda_in  input  1  sampled I2C_SDA.
- scl_oe  output  1  1 = pull SCL low, 0 = release.
- sda_oe  output  1  1 = pull SDA low, 0 = release.

## Operation
- Reset (RESET_n=0 at an edge): scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0, rdata=8'h00, state IDLE, quarter counter 0. Reset mid-transaction releases both lines on the next edge. No STOP is generated, and the bus may be left mid-frame by design.
- Accept: in IDLE with cmd_valid=1, latch {cmd_addr, cmd_rw}, cmd_wdata. busy=1 next cycle and ack_error clears. cmd_valid while busy=1 is ignored. There is no queue.
- States: IDLE -> START -> ADDR (8 bits) -> AACK -> WRITE (8 bits) -> DACK -> STOP -> IDLE (write); or AACK -> READ (8 bits) -> MNACK -> STOP (read). AACK with sda_in=1 sets ack_error and goes straight to STOP. DACK with sda_in=1 sets ack_error and continues to STOP.
- Each state step is 4 quarters q0..q3, each QTR_DIV cycles.
- START: q0,q1 both released; q2,q3 sda_oe=1, scl released.
- Data/ack bit: q0 scl_oe=1, SDA updated at q0 start; q1 scl_oe=1; q2,q3 SCL released. Bits are sent MSB first. Master-driven bit: sda_oe = ~bit. ACK and READ bits: sda_oe=0. MNACK: sda_oe=0, so the master NACKs the single read byte.
- Sampling: sda_in is captured on the last PCLK of q3. READ shifts into rdata MSB-first. The final rdata update occurs at MNACK.
- STOP: q0,q1 scl_oe=1, sda_oe=1; q2 SCL released, sda_oe=1; q3 both released. done=1 on the cycle after q3 ends, with busy=0 in the same cycle.
- Clock stretching: during q2 of any bit or STOP, the quarter counter holds while scl_oe=0 and scl_in=0. Counting resumes the first cycle scl_in=1.
- No arbitration and no repeated START.

## Timing
- Accept to first SDA fall (START q2): 1 + 2*QTR_DIV cycles.
- Write or read without stretch: accept to done = 1 + 80*QTR_DIV + 1 cycles (START 4 + 36 + 36 + STOP 4 quarters).
- Address NACK: accept to done = 1 + 44*QTR_DIV + 1 cycles.
- SDA changes only while SCL is driven low, except in START/STOP.
- done is high for exactly 1 cycle. A new command is accepted no earlier than the done cycle.

## Test plan
- Write: QTR_DIV=4, bench slave model ACKs at 7'b1010110, cmd write 8'h5A -> bus shows START, 0xAC, ACK, 0x5A, ACK, STOP. done at accept+322 cycles, ack_error=0, and the model receives 0x5A.
- Read: model returns 8'hC3 -> address byte 0xAD, master NACK on 9th bit, rdata=8'hC3 with done, ack_error=0.
- Address NACK: address 7'h10 with no responder -> STOP after AACK, done at accept+178, ack_error=1, no data clocks.
- Stretch: model holds SCL low 37 cycles at the DACK q2 -> done is delayed by exactly 37 cycles and the data is correct.
- Reset mid-op: RESET_n=0 during the WRITE bit 3 -> next edge scl_oe=0, sda_oe=0, busy=0. A following command completes normally.
- Busy ignore: cmd_valid pulsed while busy -> no effect. The second command is accepted only after done.

Source files
------------

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address + R/W, one data byte, STOP.
// SCL and SDA are open-drain; *_oe=1 pulls the line low, 0 releases it.
// Each protocol step is four quarters of QTR_DIV PCLK cycles each.
module i2c_master_byte #(
    parameter int QTR_DIV = 250
) (
    input  logic       PCLK,
    input  logic       RESET_n,
    input  logic       cmd_valid,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [7:0] rdata,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_DACK, S_READ, S_MNACK, S_STOP
    } state_t;

    localparam logic [9:0] CNT_LAST = 10'(QTR_DIV - 1);

    state_t     state, state_nxt;
    logic [9:0] qcnt;
    logic [1:0] qtr;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] wdata_q;
    logic [7:0] rx_sr;
    logic       rw_q;

    logic qtr_last;
    logic step_end;
    logic stretch_hold;

    assign qtr_last = (qcnt == CNT_LAST);
    assign step_end = qtr_last && (qtr == 2'd3);
    // A slave may hold SCL low while we release it in q2; the quarter waits for it.
    assign stretch_hold = (state != S_IDLE) && (state != S_START) &&
                          (qtr == 2'd2) && !scl_oe && !scl_in;

    // State register.
    // NOTE: reset is sampled on the clock edge here, so it lives inside the
    // clocked block rather than in the sensitivity list.
    always_ff @(posedge PCLK) begin
        if (!RESET_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: advance one protocol step every four quarters.
    // NOTE: defaulting state_nxt before the case keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_START;
            S_START: if (step_end) state_nxt = S_ADDR;
            S_ADDR:  if (step_end && bit_cnt == 3'd7) state_nxt = S_AACK;
            S_AACK:  if (step_end) state_nxt = sda_in ? S_STOP : (rw_q ? S_READ : S_WRITE);
            S_WRITE: if (step_end && bit_cnt == 3'd7) state_nxt = S_DACK;
            S_DACK:  if (step_end) state_nxt = S_STOP;
            S_READ:  if (step_end && bit_cnt == 3'd7) state_nxt = S_MNACK;
            S_MNACK: if (step_end) state_nxt = S_STOP;
            S_STOP:  if (step_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Quarter timing, shift registers, command latch and status flags.
    // NOTE: clocked state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge PCLK) begin
        if (!RESET_n) begin
            qcnt      <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            wdata_q   <= '0;
            rx_sr     <= '0;
            rw_q      <= 1'b0;
            ack_error <= 1'b0;
            rdata     <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_STOP) && step_end;
            if (state == S_IDLE) begin
                qcnt    <= '0;
                qtr     <= '0;
                bit_cnt <= '0;
                if (cmd_valid) begin
                    tx_sr     <= {cmd_addr, cmd_rw};
                    wdata_q   <= cmd_wdata;
                    rw_q      <= cmd_rw;
                    ack_error <= 1'b0;
                end
            end else begin
                if (!stretch_hold) begin
                    if (qtr_last) begin
                        qcnt <= '0;
                        qtr  <= qtr + 2'd1;
                    end else begin
                        qcnt <= qcnt + 10'd1;
                    end
                end
                if (step_end) begin
                    case (state)
                        S_ADDR, S_WRITE: begin
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        S_READ: begin
                            rx_sr   <= {rx_sr[6:0], sda_in};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        S_AACK: begin
                            if (sda_in) ack_error <= 1'b1;
                            tx_sr <= wdata_q;
                        end
                        S_DACK:  if (sda_in) ack_error <= 1'b1;
                        S_MNACK: rdata <= rx_sr;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Line drivers: SCL low in q0/q1 of every bit, SDA per step type.
    always_comb begin
        busy   = (state != S_IDLE);
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            S_START: sda_oe = qtr[1];
            S_ADDR, S_WRITE: begin
                scl_oe = ~qtr[1];
                sda_oe = ~tx_sr[7];
            end
            S_AACK, S_DACK, S_READ, S_MNACK: scl_oe = ~qtr[1];
            S_STOP: begin
                scl_oe = ~qtr[1];
                sda_oe = (qtr != 2'd3);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: a behavioural slave on the bus, a scoreboard of
// expected transaction outcomes, and a monitor that checks every done pulse.
module tb_i2c_master_byte;

    localparam int         Q        = 4;
    localparam logic [6:0] SLV_ADDR = 7'b1010110;
    localparam int         STRETCH  = 37;

    logic       PCLK      = 1'b0;
    logic       RESET_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic [6:0] cmd_addr  = '0;
    logic [7:0] cmd_wdata = '0;
    logic       busy, done, ack_error;
    logic [7:0] rdata;
    logic       scl_oe, sda_oe;
    logic       slv_scl_pull = 1'b0;
    logic       slv_sda_pull = 1'b0;
    logic       scl_line, sda_line;

    assign scl_line = !(scl_oe || slv_scl_pull);
    assign sda_line = !(sda_oe || slv_sda_pull);

    i2c_master_byte #(.QTR_DIV(Q)) dut (
        .PCLK(PCLK), .RESET_n(RESET_n),
        .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .busy(busy), .done(done), .ack_error(ack_error), .rdata(rdata),
        .scl_in(scl_line), .sda_in(sda_line), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic [7:0] slv_rbyte  = 8'h00;
    logic       stretch_en = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;
    logic       active = 1'b0, addressed = 1'b0, is_read = 1'b0;
    int         bitn = 0, byte_idx = 0, stretch_left = 0;
    logic [7:0] sh = '0;
    // Observations of the most recent frame, compared by the monitor.
    int         obs_starts = 0, obs_start_cyc = 0, obs_rises = 0;
    logic       obs_stop = 1'b0, obs_mack = 1'b0;
    logic [7:0] obs_addr_byte = '0, obs_wbyte = '0;

    always @(negedge PCLK) begin
        logic sl, sd;
        if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) slv_scl_pull = 1'b0;
        end
        if (stretch_en && active && addressed && !is_read && byte_idx == 1 && bitn == 8 &&
            prev_scl_oe && !scl_oe) begin
            slv_scl_pull = 1'b1;
            stretch_left = STRETCH;
        end
        sl = !(scl_oe || slv_scl_pull);
        sd = !(sda_oe || slv_sda_pull);
        if (prev_scl && sl && prev_sda && !sd) begin
            active = 1'b1; bitn = 0; byte_idx = 0; sh = '0;
            addressed = 1'b0; is_read = 1'b0;
            obs_starts++; obs_start_cyc = cyc; obs_rises = 0; obs_stop = 1'b0;
            obs_mack = 1'b0; obs_addr_byte = '0; obs_wbyte = '0;
        end else if (prev_scl && sl && !prev_sda && sd) begin
            active = 1'b0; obs_stop = 1'b1; slv_sda_pull = 1'b0;
        end else if (active && !prev_scl && sl) begin
            obs_rises++;
            if (bitn < 8) begin
                sh = {sh[6:0], sd};
                bitn++;
            end else begin
                if (byte_idx == 1 && is_read) obs_mack = sd;
                bitn = 0;
                byte_idx++;
            end
        end else if (active && prev_scl && !sl) begin
            if (bitn == 8) begin
                if (byte_idx == 0) begin
                    obs_addr_byte = sh;
                    addressed = (sh[7:1] == SLV_ADDR);
                    is_read = sh[0];
                    slv_sda_pull = addressed;
                end else if (byte_idx == 1 && !is_read) begin
                    obs_wbyte = sh;
                    slv_sda_pull = addressed;
                end else begin
                    slv_sda_pull = 1'b0;
                end
            end else if (byte_idx == 1 && is_read && addressed) begin
                slv_sda_pull = !slv_rbyte[7 - bitn];
            end else begin
                slv_sda_pull = 1'b0;
            end
        end
        prev_scl    = !(scl_oe || slv_scl_pull);
        prev_sda    = !(sda_oe || slv_sda_pull);
        prev_scl_oe = scl_oe;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        int         accept_cyc;
        int         span;
        int         rises;
        logic       rw;
        logic       addressed;
        logic       ack_err;
        logic [7:0] rdata;
        logic [7:0] addr_byte;
        logic [7:0] wbyte;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_rdata = 8'h00;
    int         n_starts = 0;
    logic       prev_done = 1'b0;

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge PCLK) begin
        exp_t e;
        if (RESET_n && done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("done_has_expectation", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                // span counts the accept cycle and the done cycle inclusively
                check("accept_to_done_span", 32'(cyc - e.accept_cyc + 1), 32'(e.span));
                check("accept_to_sda_fall", 32'(obs_start_cyc - e.accept_cyc), 32'(1 + 2 * Q));
                check("ack_error", 32'(ack_error), 32'(e.ack_err));
                check("rdata", 32'(rdata), 32'(e.rdata));
                check("busy_low_with_done", 32'(busy), 32'd0);
                check("bus_addr_byte", 32'(obs_addr_byte), 32'(e.addr_byte));
                check("bus_scl_rises", 32'(obs_rises), 32'(e.rises));
                check("bus_stop_seen", 32'(obs_stop), 32'd1);
                if (e.addressed && !e.rw) check("slave_got_wdata", 32'(obs_wbyte), 32'(e.wbyte));
                if (e.addressed && e.rw) check("master_nack_on_read", 32'(obs_mack), 32'd1);
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PCLK);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_within_budget", 32'(ok), 32'd1);
    endtask

    // Issue one command once the master is idle and record what it should produce.
    task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rbyte, input int stretch, input bit expect_done);
        exp_t e;
        wait_idle();
        slv_rbyte  = rbyte;
        stretch_en = (stretch != 0);
        cmd_valid  = 1'b1;
        cmd_rw     = rw;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        e.accept_cyc = cyc;
        e.rw         = rw;
        e.addressed  = (addr == SLV_ADDR);
        e.ack_err    = !e.addressed;
        e.addr_byte  = {addr, rw};
        e.wbyte      = wdata;
        if (rw && e.addressed) last_rdata = rbyte;
        e.rdata = last_rdata;
        // full frame: 9 + 9 clocks plus the STOP clock; NACKed address: 9 plus STOP
        e.rises = e.addressed ? 19 : 10;
        e.span  = 2 + Q * (e.addressed ? 80 : 44) + ((e.addressed && !rw) ? stretch : 0);
        if (expect_done) sb.push_back(e);
        n_starts++;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge PCLK);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_scl_oe", 32'(scl_oe), 32'd0);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_ack_error", 32'(ack_error), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        RESET_n = 1'b1;

        issue(1'b0, SLV_ADDR, 8'h5A, 8'h00, 0, 1'b1);        // write
        issue(1'b1, SLV_ADDR, 8'h00, 8'hC3, 0, 1'b1);        // read
        issue(1'b0, 7'h10,    8'hA5, 8'h00, 0, 1'b1);        // address NACK
        issue(1'b0, SLV_ADDR, 8'h7E, 8'h00, STRETCH, 1'b1);  // stretch at DACK

        // Reset in the middle of WRITE bit 3.
        issue(1'b0, SLV_ADDR, 8'h96, 8'h00, 0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PCLK);
            if (active && byte_idx == 1 && bitn == 3 && scl_oe) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_write_bit3", 32'(found), 32'd1);
        RESET_n = 1'b0;
        @(posedge PCLK);
        #1;
        check("midop_reset_scl_oe", 32'(scl_oe), 32'd0);
        check("midop_reset_sda_oe", 32'(sda_oe), 32'd0);
        check("midop_reset_busy", 32'(busy), 32'd0);
        check("midop_reset_rdata", 32'(rdata), 32'd0);
        @(negedge PCLK);
        RESET_n = 1'b1;
        last_rdata = 8'h00;
        repeat (4) @(negedge PCLK);
        issue(1'b0, SLV_ADDR, 8'h21, 8'h00, 0, 1'b1);

        // A request while busy must be ignored; the next one waits for done.
        issue(1'b0, SLV_ADDR, 8'h3C, 8'h00, 0, 1'b1);
        repeat (20) @(negedge PCLK);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h55; cmd_wdata = 8'hFF;
        check("busy_during_ignored_pulse", 32'(busy), 32'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        issue(1'b1, SLV_ADDR, 8'h00, 8'h81, 0, 1'b1);

        // Randomized mix of reads, writes, hits and misses.
        for (int n = 0; n < 12; n++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 2) != 0) ? SLV_ADDR : 7'($urandom);
            issue(1'($urandom), a, 8'($urandom), 8'($urandom), 0, 1'b1);
        end

        wait_idle();
        repeat (10) @(negedge PCLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("start_count", 32'(obs_starts), 32'(n_starts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
